// File: rtl/portamento_scheduler.sv
// portamento_scheduler: round-robin scan of four voice targets through one
// shared portamento filter. Each tick_en runs one scan of units 0..3; every
// slot is SETUP, PULSE, WAIT (WAIT_CYC cycles) and CAPTURE.
// Optional feature macro: PORTA_GLIDE_BYPASS_EN adds a per-unit bypass input
// that makes the captured pitch the target snapshot instead of the filter output.
module portamento_scheduler #(
    parameter int DSZ      = 52,
    parameter int NUNITS   = 4,
    parameter int WAIT_CYC = 3
) (
    input  logic           clk50mhz,
    input  logic           reset,
    input  logic           tick_en,
    input  logic           tgt_we,
    input  logic [1:0]     tgt_unit,
    input  logic [DSZ-1:0] tgt_data,
`ifdef PORTA_GLIDE_BYPASS_EN
    input  logic [3:0]     bypass,
`endif
    output logic [1:0]     porta_unit,
    output logic           porta_clk,
    output logic [DSZ-1:0] porta_in,
    input  logic [DSZ-1:0] porta_out,
    output logic           pitch_valid,
    output logic [1:0]     pitch_unit,
    output logic [DSZ-1:0] pitch_data,
    output logic           busy,
    output logic           overrun
);

    localparam int WW    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int WLAST = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_CAPTURE} state_t;

    state_t           r_state, w_next;
    logic [1:0]       r_unit;
    logic [WW-1:0]    r_wcnt;
    logic [DSZ-1:0]   r_tgt [NUNITS];
    logic             r_pending, r_overrun;
    logic [1:0]       r_porta_unit, r_pitch_unit;
    logic [DSZ-1:0]   r_porta_in, r_pitch_data;
    logic             r_pitch_valid;
    logic             w_pclk;
    logic             w_start;
    logic             w_last_unit;
    logic [DSZ-1:0]   w_capture;

    assign w_start     = (r_state == S_IDLE) && (tick_en || r_pending);
    assign w_last_unit = (r_unit == 2'(NUNITS - 1));

`ifdef PORTA_GLIDE_BYPASS_EN
    // Bypassed units report the snapshot they were driven with.
    assign w_capture = bypass[r_unit] ? r_porta_in : porta_out;
`else
    assign w_capture = porta_out;
`endif

    // State register.
    always_ff @(posedge clk50mhz) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode and the filter action pulse.
    always_comb begin
        w_next = r_state;
        w_pclk = 1'b0;
        case (r_state)
            S_IDLE:    if (tick_en || r_pending) w_next = S_SETUP;
            S_SETUP:   w_next = S_PULSE;
            S_PULSE: begin
                w_pclk = 1'b1;
                w_next = (WAIT_CYC > 0) ? S_WAIT : S_CAPTURE;
            end
            S_WAIT:    if (r_wcnt == WW'(WLAST)) w_next = S_CAPTURE;
            S_CAPTURE: w_next = w_last_unit ? S_IDLE : S_SETUP;
            default:   w_next = S_IDLE;
        endcase
    end

    // Targets, request queueing, slot datapath and captured outputs.
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            for (int i = 0; i < NUNITS; i++) r_tgt[i] <= '0;
            r_unit        <= '0;
            r_wcnt        <= '0;
            r_pending     <= 1'b0;
            r_overrun     <= 1'b0;
            r_porta_unit  <= '0;
            r_porta_in    <= '0;
            r_pitch_valid <= 1'b0;
            r_pitch_unit  <= '0;
            r_pitch_data  <= '0;
        end else begin
            if (tgt_we) r_tgt[tgt_unit] <= tgt_data;

            // One request may queue behind a running scan; a second is lost.
            // In IDLE a pending request starts the scan and a coincident tick stays queued.
            if (r_state == S_IDLE)
                r_pending <= r_pending && tick_en;
            else if (tick_en) begin
                if (r_pending) r_overrun <= 1'b1;
                else           r_pending <= 1'b1;
            end

            r_pitch_valid <= (r_state == S_CAPTURE);

            if (w_start) r_unit <= '0;

            case (r_state)
                S_SETUP: begin
                    r_porta_unit <= r_unit;
                    r_porta_in   <= r_tgt[r_unit];
                    r_wcnt       <= '0;
                end
                S_WAIT:  r_wcnt <= r_wcnt + 1'b1;
                S_CAPTURE: begin
                    r_pitch_data <= w_capture;
                    r_pitch_unit <= r_unit;
                    r_unit       <= r_unit + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign porta_unit  = r_porta_unit;
    assign porta_clk   = w_pclk;
    assign porta_in    = r_porta_in;
    assign pitch_valid = r_pitch_valid;
    assign pitch_unit  = r_pitch_unit;
    assign pitch_data  = r_pitch_data;
    assign busy        = (r_state != S_IDLE);
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_portamento_scheduler.sv
// Scoreboard bench for portamento_scheduler: each accepted scan request pushes
// the four expected filter slots and four expected captured pitches; a
// negedge monitor pops and compares as the DUT produces them.
module tb_portamento_scheduler;

    localparam int DSZ = 52;

    logic           clk50mhz = 1'b0;
    logic           reset, tick_en, tgt_we;
    logic [1:0]     tgt_unit;
    logic [DSZ-1:0] tgt_data;
    logic [1:0]     porta_unit, pitch_unit;
    logic           porta_clk, pitch_valid, busy, overrun;
    logic [DSZ-1:0] porta_in, porta_out, pitch_data;
    logic [3:0]     bypass_m = 4'b0000;
    logic [DSZ-1:0] off = '0;

    typedef struct {
        logic [1:0]     u;
        logic [DSZ-1:0] d;
    } ent_t;

    ent_t           q_slot[$];
    ent_t           q_pit[$];
    logic [DSZ-1:0] tgt_m [4];
    int             n_vec = 0;
    int             n_err = 0;
    int             cyc = 0;
    int             pcyc = 0;
    int             bcnt = 0;

    always #10 clk50mhz = ~clk50mhz;
    always @(posedge clk50mhz) cyc <= cyc + 1;

    // Filter model: output depends only on the selected unit plus an offset.
    assign porta_out = DSZ'({porta_unit, 4'h0}) + off;

    portamento_scheduler #(.DSZ(DSZ), .NUNITS(4), .WAIT_CYC(3)) dut (
        .clk50mhz   (clk50mhz),
        .reset      (reset),
        .tick_en    (tick_en),
        .tgt_we     (tgt_we),
        .tgt_unit   (tgt_unit),
        .tgt_data   (tgt_data),
`ifdef PORTA_GLIDE_BYPASS_EN
        .bypass     (bypass_m),
`endif
        .porta_unit (porta_unit),
        .porta_clk  (porta_clk),
        .porta_in   (porta_in),
        .porta_out  (porta_out),
        .pitch_valid(pitch_valid),
        .pitch_unit (pitch_unit),
        .pitch_data (pitch_data),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk50mhz);
        #1;
    endtask

    task automatic wr(input logic [1:0] u, input logic [DSZ-1:0] d);
        tgt_we = 1'b1; tgt_unit = u; tgt_data = d;
        step(1);
        tgt_we = 1'b0;
        tgt_m[u] = d;
    endtask

    // Expected slots and pitches of one scan, from the current target model.
    task automatic push_scan();
        ent_t e;
        for (int u = 0; u < 4; u++) begin
            e.u = 2'(u); e.d = tgt_m[u];
            q_slot.push_back(e);
            e.d = bypass_m[u] ? tgt_m[u] : (DSZ'(u * 16) + off);
            q_pit.push_back(e);
        end
    endtask

    // Returns in scan cycle 0 (the SETUP of unit 0).
    task automatic tick_go();
        push_scan();
        tick_en = 1'b1;
        step(1);
        tick_en = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k;
        for (k = 0; k < max; k++) begin
            step(1);
            if (!busy && q_pit.size() == 0 && q_slot.size() == 0) break;
        end
        if (k == max) chk("timeout", 1, 0);
    endtask

    // Output monitor, sampled away from the active edge.
    always @(negedge clk50mhz) begin
        ent_t e;
        if (reset) bcnt = 0;
        else begin
            if (busy) bcnt++;
            else if (bcnt != 0) begin
                chk("busy_len", 64'(bcnt), 24);
                bcnt = 0;
            end
            if (porta_clk) begin
                if (q_slot.size() == 0) chk("spurious_porta_clk", 1, 0);
                else begin
                    e = q_slot.pop_front();
                    chk("porta_unit", 64'(porta_unit), 64'(e.u));
                    chk("porta_in", 64'(porta_in), 64'(e.d));
                end
                pcyc = cyc;
            end
            if (pitch_valid) begin
                if (q_pit.size() == 0) chk("spurious_pitch_valid", 1, 0);
                else begin
                    e = q_pit.pop_front();
                    chk("pitch_unit", 64'(pitch_unit), 64'(e.u));
                    chk("pitch_data", 64'(pitch_data), 64'(e.d));
                    chk("slot_latency", 64'(cyc - pcyc), 5);
                    chk("unit_hold", 64'(porta_unit), 64'(pitch_unit));
                end
            end
        end
    end

    task automatic chk_zero(input string pfx);
        chk({pfx, "_porta_unit"}, 64'(porta_unit), 0);
        chk({pfx, "_porta_clk"}, 64'(porta_clk), 0);
        chk({pfx, "_porta_in"}, 64'(porta_in), 0);
        chk({pfx, "_pitch_valid"}, 64'(pitch_valid), 0);
        chk({pfx, "_pitch_unit"}, 64'(pitch_unit), 0);
        chk({pfx, "_pitch_data"}, 64'(pitch_data), 0);
        chk({pfx, "_busy"}, 64'(busy), 0);
        chk({pfx, "_overrun"}, 64'(overrun), 0);
    endtask

    initial begin
        reset = 1'b1; tick_en = 1'b0; tgt_we = 1'b0; tgt_unit = '0; tgt_data = '0;
        for (int i = 0; i < 4; i++) tgt_m[i] = '0;
        step(3);
        reset = 1'b0;
        chk_zero("rst");

        // Basic scan: one programmed target, filter output unit*0x10.
        wr(2'd2, DSZ'(64'h1234));
        tick_go();
        wait_idle(100);

        // Different targets and filter offset.
        off = DSZ'(64'h5000);
        wr(2'd0, DSZ'(64'hAAA));
        wr(2'd3, DSZ'(64'hF_FFFF_FFFF_FFFF));
        tick_go();
        wait_idle(100);

        // Queued request at cycle 5, dropped request at cycle 10.
        tick_go();
        step(5);
        tick_en = 1'b1; push_scan();
        step(1);
        tick_en = 1'b0;
        step(4);
        tick_en = 1'b1;
        step(1);
        tick_en = 1'b0;
        chk("overrun_set", 64'(overrun), 1);
        step(13);
        chk("gap_idle", 64'(busy), 0);
        step(1);
        chk("second_scan_start", 64'(busy), 1);
        wait_idle(100);
        chk("overrun_sticky", 64'(overrun), 1);

        // Target write during unit 1 SETUP applies from the next scan.
        tick_go();
        step(6);
        tgt_we = 1'b1; tgt_unit = 2'd1; tgt_data = DSZ'(64'h777);
        step(1);
        tgt_we = 1'b0;
        tgt_m[1] = DSZ'(64'h777);
        wait_idle(100);
        tick_go();
        wait_idle(100);

`ifdef PORTA_GLIDE_BYPASS_EN
        bypass_m = 4'b0001;
        tick_go();
        wait_idle(100);
        bypass_m = 4'b0000;
`endif

        // Reset at scan cycle 9 with a coincident tick: scan aborts, tick ignored.
        tick_go();
        step(9);
        reset = 1'b1; tick_en = 1'b1;
        step(1);
        tick_en = 1'b0;
        q_slot.delete(); q_pit.delete();
        for (int i = 0; i < 4; i++) tgt_m[i] = '0;
        step(1);
        reset = 1'b0;
        chk_zero("abort");
        step(40);
        chk("abort_quiet_busy", 64'(busy), 0);

        // Recovery scan after reset: cleared targets.
        off = DSZ'(64'h42);
        tick_go();
        wait_idle(100);

        chk("slots_left", 64'(q_slot.size()), 0);
        chk("pitches_left", 64'(q_pit.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
